// File: rtl/cfu_sha256_queue_if.sv
// CFU request/response bundle between the core (master) and a function unit (slave).
interface cfu_sha256_queue_if #(
   parameter int ID_W   = 3,
   parameter int FUNC_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [7:0]        req_cfu;
   logic [FUNC_W-1:0] req_func;
   logic [ID_W-1:0]   req_id;
   logic [31:0]       req_data0;
   logic [31:0]       req_data1;
   logic              resp_valid;
   logic              resp_ready;
   logic [ID_W-1:0]   resp_id;
   logic              resp_status;
   logic [31:0]       resp_data;

   modport master (
      output req_valid, req_cfu, req_func, req_id, req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_status, resp_data
   );

   modport slave (
      input  req_valid, req_cfu, req_func, req_id, req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_id, resp_status, resp_data
   );
endinterface

// File: rtl/cfu_sha256_queue.sv
// SHA-256 helper / CRC32 CFU slave with an in-order response FIFO.
// Define CFU_CRC32_EN to build the multi-cycle CRC32 engine; otherwise req_cfu=0 is illegal.
module cfu_sha256_queue #(
   parameter int RESP_DEPTH = 4,
   parameter int ID_W       = 3,
   parameter int FUNC_W     = 4
) (
   input logic clk,
   input logic rst,
   cfu_sha256_queue_if.slave cfu
);
   localparam int PW = $clog2(RESP_DEPTH);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            status;
      logic [31:0]     data;
   } resp_t;

   typedef enum logic {IDLE, CRC_RUN} state_t;

   state_t        state, state_nxt;
   resp_t         mem [RESP_DEPTH];
   resp_t         req_ent, push_ent;
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   count;
   logic          full, empty, fire, push, pop, push_imm;
   logic          crc_req, crc_last, crc_push;
   logic [31:0]   op3;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   assign full  = (count == (PW+1)'(RESP_DEPTH));
   assign empty = (count == '0);
   assign fire  = cfu.req_valid & cfu.req_ready;
   assign pop   = cfu.resp_ready & ~empty;

   // SHA and illegal ops resolve in the accept cycle; only CRC defers its push.
   always_comb begin
      req_ent    = '0;
      req_ent.id = cfu.req_id;
      if (cfu.req_cfu == 8'd1) begin
         case (int'(cfu.req_func))
            0: req_ent.data = rotr(cfu.req_data0, 7) ^ rotr(cfu.req_data0, 18) ^ (cfu.req_data0 >> 3);
            1: req_ent.data = rotr(cfu.req_data0, 17) ^ rotr(cfu.req_data0, 19) ^ (cfu.req_data0 >> 10);
            2: req_ent.data = rotr(cfu.req_data0, 2) ^ rotr(cfu.req_data0, 13) ^ rotr(cfu.req_data0, 22);
            3: req_ent.data = rotr(cfu.req_data0, 6) ^ rotr(cfu.req_data0, 11) ^ rotr(cfu.req_data0, 25);
            4: req_ent.data = (cfu.req_data0 & cfu.req_data1) ^ (~cfu.req_data0 & op3);
            5: req_ent.data = (cfu.req_data0 & cfu.req_data1) ^ (cfu.req_data0 & op3) ^
                              (cfu.req_data1 & op3);
            6: req_ent.data = '0;
            default: req_ent.status = 1'b1;
         endcase
      end else begin
         req_ent.status = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op3 <= '0;
      else if (fire && cfu.req_cfu == 8'd1 && int'(cfu.req_func) == 6)
         op3 <= cfu.req_data0;
   end

`ifdef CFU_CRC32_EN
   logic [31:0]     crc_q, crc_dat, crc_nxt;
   logic [1:0]      crc_cnt;
   logic [ID_W-1:0] crc_id;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign crc_req  = (cfu.req_cfu == 8'd0);
   assign crc_last = (crc_cnt == 2'd3);
   assign crc_nxt  = crc_byte(crc_q, crc_dat[7:0]);
   assign push_ent = crc_push ? '{id: crc_id, status: 1'b0, data: crc_nxt} : req_ent;

   // Data word is consumed low byte first by shifting it down each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q   <= '0;
         crc_dat <= '0;
         crc_cnt <= '0;
         crc_id  <= '0;
      end else if (fire && crc_req) begin
         crc_q   <= cfu.req_data0;
         crc_dat <= cfu.req_data1;
         crc_cnt <= '0;
         crc_id  <= cfu.req_id;
      end else if (state == CRC_RUN) begin
         crc_q   <= crc_nxt;
         crc_dat <= crc_dat >> 8;
         crc_cnt <= crc_cnt + 2'd1;
      end
   end
`else
   assign crc_req  = 1'b0;
   assign crc_last = 1'b1;
   assign push_ent = req_ent;
`endif

   assign push_imm = fire & ~crc_req;
   assign push     = push_imm | crc_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fire && crc_req) state_nxt = CRC_RUN;
         CRC_RUN: if (crc_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Accept already guaranteed a free slot, so the CRC push never meets a full FIFO.
   always_comb begin
      cfu.req_ready = (state == IDLE) && !full;
      crc_push      = (state == CRC_RUN) && crc_last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_ent;
   end

   assign cfu.resp_valid  = ~empty;
   assign cfu.resp_id     = empty ? '0 : mem[rptr].id;
   assign cfu.resp_status = empty ? 1'b0 : mem[rptr].status;
   assign cfu.resp_data   = empty ? '0 : mem[rptr].data;
endmodule

// File: tb/tb_cfu_sha256_queue.sv
// Directed scoreboard bench: issue tasks queue expected responses, a negedge monitor checks pops.
module tb_cfu_sha256_queue;
   typedef struct packed {
      logic [2:0]  id;
      logic        st;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   cfu_sha256_queue_if #(.ID_W(3), .FUNC_W(4)) m ();

   cfu_sha256_queue #(.RESP_DEPTH(4), .ID_W(3), .FUNC_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .cfu (m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && m.resp_valid && m.resp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(m.resp_id), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_id", 32'(m.resp_id), 32'(e.id));
            chk("resp_status", 32'(m.resp_status), 32'(e.st));
            chk("resp_data", m.resp_data, e.data);
         end
      end
   end

   task automatic issue(input logic [7:0] cfu, input logic [3:0] func, input logic [2:0] id,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic st, input logic [31:0] exp, input bit push_exp);
      bit acc = 0;
      int n = 0;
      m.req_valid = 1'b1;
      m.req_cfu   = cfu;
      m.req_func  = func;
      m.req_id    = id;
      m.req_data0 = d0;
      m.req_data1 = d1;
      do begin
         @(negedge clk);
         acc = m.req_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      m.req_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'(n), 32'd0);
      else if (push_exp) sb.push_back('{id: id, st: st, data: exp});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int lo;
      m.req_valid  = 1'b0;
      m.req_cfu    = '0;
      m.req_func   = '0;
      m.req_id     = '0;
      m.req_data0  = '0;
      m.req_data1  = '0;
      m.resp_ready = 1'b0;

      #12;
      chk("rst_resp_valid", 32'(m.resp_valid), 32'd0);
      chk("rst_req_ready", 32'(m.req_ready), 32'd1);
      chk("rst_resp_id", 32'(m.resp_id), 32'd0);
      chk("rst_resp_status", 32'(m.resp_status), 32'd0);
      chk("rst_resp_data", m.resp_data, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      m.resp_ready = 1'b1;

      // Latency-1 SHA result visible the cycle after accept.
      issue(8'd1, 4'd0, 3'd2, 32'h1, 32'h0, 1'b0, 32'h0200_4000, 1);
      @(negedge clk);
      chk("sig0_lat_valid", 32'(m.resp_valid), 32'd1);
      chk("sig0_lat_id", 32'(m.resp_id), 32'd2);
      wait_drain();

      issue(8'd1, 4'd1, 3'd3, 32'h1, 32'h0, 1'b0, 32'h0000_A000, 1);
      issue(8'd1, 4'd2, 3'd4, 32'h1, 32'h0, 1'b0, 32'h4008_0400, 1);
      issue(8'd1, 4'd3, 3'd5, 32'h1, 32'h0, 1'b0, 32'h0420_0080, 1);
      issue(8'd1, 4'd6, 3'd6, 32'h0, 32'h0, 1'b0, 32'h0, 1);
      issue(8'd1, 4'd4, 3'd7, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 32'h1234_0000, 1);
      issue(8'd1, 4'd6, 3'd0, 32'hF0F0_F0F0, 32'h0, 1'b0, 32'h0, 1);
      issue(8'd1, 4'd5, 3'd1, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'hFF00_FF00, 1);
      issue(8'd1, 4'd9, 3'd5, 32'h1234, 32'h5678, 1'b1, 32'h0, 1);
      issue(8'd1, 4'd7, 3'd6, 32'h1234, 32'h5678, 1'b1, 32'h0, 1);
      issue(8'd2, 4'd0, 3'd2, 32'h1, 32'h0, 1'b1, 32'h0, 1);
      wait_drain();

      // CRC32 over four zero bytes, followed by a queued SHA op.
`ifdef CFU_CRC32_EN
      issue(8'd0, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'hDEBB_20E3, 1);
`else
      issue(8'd0, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1);
`endif
      lo = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m.req_ready) break;
         lo++;
      end
`ifdef CFU_CRC32_EN
      chk("crc_busy_cycles", 32'(lo), 32'd4);
`else
      chk("crc_busy_cycles", 32'(lo), 32'd0);
`endif
      @(posedge clk); #1;
      issue(8'd1, 4'd0, 3'd4, 32'h1, 32'h0, 1'b0, 32'h0200_4000, 1);
`ifdef CFU_CRC32_EN
      issue(8'd0, 4'd0, 3'd3, 32'h0, 32'h0, 1'b0, 32'h0, 1);
`endif
      wait_drain();

      // Fill the FIFO with resp_ready low, then drain in order.
      m.resp_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         issue(8'd1, 4'd0, 3'(k), 32'h1 << k, 32'h0, 1'b0,
               (32'h0200_4000 << k) | (32'h1 >> (3 - k)), 1);
      @(negedge clk);
      chk("full_req_ready", 32'(m.req_ready), 32'd0);
      chk("full_head_id", 32'(m.resp_id), 32'd0);
      @(posedge clk); #1;
      chk("stall_head_id", 32'(m.resp_id), 32'd0);
      m.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_pop", 32'(m.req_ready), 32'd1);
      wait_drain();

      // Reset with a queued response and (if built) a CRC in flight.
      m.resp_ready = 1'b0;
      issue(8'd1, 4'd0, 3'd6, 32'h1, 32'h0, 1'b0, 32'h0, 0);
`ifdef CFU_CRC32_EN
      issue(8'd0, 4'd0, 3'd7, 32'h1, 32'h2, 1'b0, 32'h0, 0);
      @(posedge clk); #1;
`endif
      rst = 1'b1;
      #1;
      chk("midrst_resp_valid", 32'(m.resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(m.req_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      m.resp_ready = 1'b1;
      // op3 back to zero: ch with x=0 returns op3.
      issue(8'd1, 4'd4, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1);
      issue(8'd1, 4'd3, 3'd3, 32'h1, 32'h0, 1'b0, 32'h0420_0080, 1);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
